// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    DATA,
    WR,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned sizes exist only for loads; everything else is illegal.
  function automatic logic is_legal_funct3(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: load extract with sign/zero extension and
// store merge into a previously read word. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rd_word,
  input  logic [31:0] st_wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Select the addressed byte/half and extend it according to funct3.
  always_comb begin
    lane_byte = '0;
    case (offset)
      2'd0: lane_byte = rd_word[7:0];
      2'd1: lane_byte = rd_word[15:8];
      2'd2: lane_byte = rd_word[23:16];
      2'd3: lane_byte = rd_word[31:24];
      default: lane_byte = '0;
    endcase
    lane_half = offset[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    case (funct3)
      F3_B:  load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_BU: load_data = {24'h0, lane_byte};
      F3_H:  load_data = {{16{lane_half[15]}}, lane_half};
      F3_HU: load_data = {16'h0, lane_half};
      default: load_data = rd_word;
    endcase
  end

  // Replace the addressed byte/half of the old word with store data.
  always_comb begin
    store_word = st_wdata;
    case (funct3)
      F3_B: begin
        store_word = rd_word;
        case (offset)
          2'd0: store_word[7:0]   = st_wdata[7:0];
          2'd1: store_word[15:8]  = st_wdata[7:0];
          2'd2: store_word[23:16] = st_wdata[7:0];
          2'd3: store_word[31:24] = st_wdata[7:0];
          default: store_word = rd_word;
        endcase
      end
      F3_H: begin
        store_word = rd_word;
        if (offset[1]) store_word[31:16] = st_wdata[15:0];
        else           store_word[15:0]  = st_wdata[15:0];
      end
      default: store_word = st_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: word-granular data-memory initiator with RMW for
// sub-word stores. Build option: LSU_MISALIGN_TRAP_EN (defined = misaligned
// H/W accesses return an error; undefined = address is force-aligned).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [31:0]           mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic [31:0]           mem_read_data
);

  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd4;

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic        req_err;
  logic        misalign_err;
  logic [1:0]  req_offset;
  logic [31:0] load_data;
  logic [31:0] store_word;

  lsu_lane_align u_lane_align (
    .funct3     (funct3_q),
    .offset     (offset_q),
    .rd_word    (mem_read_data),
    .st_wdata   (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Request validation and lane offset; H/W offsets are force-aligned, which
  // only matters in the non-trapping build since trapped requests never access.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_err = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_address[0]) ||
                   ((req_funct3 == F3_W) && (req_address[1:0] != 2'b00));
`else
    misalign_err = 1'b0;
`endif
    req_err = (64'(req_address) >= MEM_BYTES) ||
              !is_legal_funct3(req_write, req_funct3) || misalign_err;
    case (req_funct3)
      F3_H, F3_HU: req_offset = {req_address[1], 1'b0};
      F3_W:        req_offset = 2'b00;
      default:     req_offset = req_address[1:0];
    endcase
  end

  // Next-state and output decode; memory strobes come from state only.
  always_comb begin
    state_d          = state_q;
    write_d          = write_q;
    funct3_d         = funct3_q;
    addr_d           = addr_q;
    offset_d         = offset_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    error_d          = error_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    mem_address      = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = 32'({req_address[ADDR_WIDTH-1:2], 2'b00});
          offset_d = req_offset;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          if (req_err) begin
            error_d = 1'b1;
            state_d = RESP;
          end else if (req_write && (req_funct3 == F3_W)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        mem_read_enable = 1'b1;
        state_d         = DATA;
      end
      DATA: begin
        if (write_q) begin
          wdata_d = store_word;
          state_d = WR;
        end else begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      WR: begin
        mem_write_enable = 1'b1;
        mem_write_data   = wdata_q;
        state_d          = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          error_d = 1'b0;
          rdata_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE) mem_address = addr_q;
  end

  // State and captured request registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      offset_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      offset_q <= offset_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 1-cycle data memory.
module tb_load_store_unit;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_read_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wdata;
    logic [31:0] waddr;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] dmem [0:1023] = '{default: '0};

  load_store_unit #(
    .MEM_WORDS  (1024),
    .ADDR_WIDTH (32)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory: no byte enables, registered read.
  always @(posedge clock) begin
    if (mem_write_enable) dmem[mem_address[11:2]] <= mem_write_data;
    if (mem_read_enable)  mem_read_data <= dmem[mem_address[11:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request (called just after a falling edge) and check its response.
  task automatic issue(input string tag, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int lat,
                       input int nrd, input int nwr, input logic [31:0] exp_wd,
                       input int hold);
    exp_t e;
    exp_t got_e;
    int   cyc;
    int   rd_seen;
    int   wr_seen;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = lat;
    e.nrd   = nrd;
    e.nwr   = nwr;
    e.wdata = exp_wd;
    e.waddr = {addr[31:2], 2'b00};
    sb_q.push_back(e);
    resp_ready  = (hold == 0);
    req_valid   = 1'b1;
    req_write   = wr;
    req_funct3  = f3;
    req_address = addr;
    req_wdata   = wd;
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    req_valid   = 1'b0;
    req_address = '0;
    req_wdata   = '0;
    cyc = 0;
    rd_seen = 0;
    wr_seen = 0;
    while (cyc < 20) begin
      @(negedge clock);
      cyc++;
      check_eq({tag, "_strobe_excl"}, 32'(mem_read_enable & mem_write_enable), 32'd0);
      if (mem_read_enable) rd_seen++;
      if (mem_write_enable) begin
        wr_seen++;
        check_eq({tag, "_waddr"}, mem_address, sb_q[0].waddr);
        check_eq({tag, "_wdata"}, mem_write_data, sb_q[0].wdata);
      end
      if (resp_valid) break;
    end
    got_e = sb_q.pop_front();
    check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    check_eq({tag, "_latency"}, 32'(cyc), 32'(got_e.lat));
    check_eq({tag, "_rdata"}, resp_rdata, got_e.rdata);
    check_eq({tag, "_error"}, 32'(resp_error), 32'(got_e.err));
    check_eq({tag, "_reads"}, 32'(rd_seen), 32'(got_e.nrd));
    check_eq({tag, "_writes"}, 32'(wr_seen), 32'(got_e.nwr));
    check_eq({tag, "_maddr"}, mem_address, got_e.waddr);
    for (int i = 0; i < hold; i++) begin
      req_valid   = 1'b1;
      req_write   = 1'b1;
      req_funct3  = 3'b010;
      req_address = 32'h20;
      req_wdata   = 32'h1234_5678;
      @(negedge clock);
      check_eq({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check_eq({tag, "_hold_rdata"}, resp_rdata, got_e.rdata);
      check_eq({tag, "_hold_error"}, 32'(resp_error), 32'(got_e.err));
      check_eq({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      check_eq({tag, "_hold_strobes"}, 32'(mem_read_enable | mem_write_enable), 32'd0);
    end
    req_valid   = 1'b0;
    req_address = '0;
    req_wdata   = '0;
    resp_ready  = 1'b1;
    @(negedge clock);
    check_eq({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_post_resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_post_error"}, 32'(resp_error), 32'd0);
    check_eq({tag, "_post_maddr"}, mem_address, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_rdata"}, resp_rdata, 32'd0);
    check_eq({tag, "_error"}, 32'(resp_error), 32'd0);
    check_eq({tag, "_we"}, 32'(mem_write_enable), 32'd0);
    check_eq({tag, "_re"}, 32'(mem_read_enable), 32'd0);
    check_eq({tag, "_maddr"}, mem_address, 32'd0);
    check_eq({tag, "_mwdata"}, mem_write_data, 32'd0);
  endtask

  initial begin
    reset_n     = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_funct3  = 3'b000;
    req_address = '0;
    req_wdata   = '0;
    resp_ready  = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);

    //    tag     wr    f3      addr        wdata         exp_rd        err  lat rd wr exp_wd        hold
    issue("sw",   1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF, 0);
    issue("lw",   1'b0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 0, 32'h0,        0);
    issue("sb",   1'b1, 3'b000, 32'h012, 32'h00000055, 32'h0,        1'b0, 4, 1, 1, 32'hDE55BEEF, 0);
    issue("lbu",  1'b0, 3'b100, 32'h012, 32'h0,        32'h00000055, 1'b0, 3, 1, 0, 32'h0,        0);
    issue("lb",   1'b0, 3'b000, 32'h013, 32'h0,        32'hFFFFFFDE, 1'b0, 3, 1, 0, 32'h0,        0);
    issue("lh",   1'b0, 3'b001, 32'h010, 32'h0,        32'hFFFFBEEF, 1'b0, 3, 1, 0, 32'h0,        0);
    issue("lhu",  1'b0, 3'b101, 32'h010, 32'h0,        32'h0000BEEF, 1'b0, 3, 1, 0, 32'h0,        0);
    issue("oor",  1'b0, 3'b010, 32'h1000, 32'h0,       32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
    issue("f011", 1'b0, 3'b011, 32'h010, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
    issue("f110", 1'b0, 3'b110, 32'h010, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
    issue("sbu",  1'b1, 3'b100, 32'h010, 32'h11,       32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
`ifdef LSU_MISALIGN_TRAP_EN
    issue("lh_mis", 1'b0, 3'b001, 32'h011, 32'h0,      32'h0,        1'b1, 1, 0, 0, 32'h0,        0);
`else
    issue("lh_mis", 1'b0, 3'b001, 32'h011, 32'h0,      32'hFFFFBEEF, 1'b0, 3, 1, 0, 32'h0,        0);
`endif
    issue("sh",   1'b1, 3'b001, 32'h012, 32'h0000CAFE, 32'h0,        1'b0, 4, 1, 1, 32'hCAFEBEEF, 0);
    issue("lhu2", 1'b0, 3'b101, 32'h012, 32'h0,        32'h0000CAFE, 1'b0, 3, 1, 0, 32'h0,        0);
    issue("lw_top", 1'b0, 3'b010, 32'hFFC, 32'h0,      32'h0,        1'b0, 3, 1, 0, 32'h0,        0);
    issue("lb_top", 1'b0, 3'b000, 32'hFFF, 32'h0,      32'h0,        1'b0, 3, 1, 0, 32'h0,        0);
    issue("bp",   1'b0, 3'b010, 32'h010, 32'h0,        32'hCAFEBEEF, 1'b0, 3, 1, 0, 32'h0,        5);
    issue("lw20", 1'b0, 3'b010, 32'h020, 32'h0,        32'h0,        1'b0, 3, 1, 0, 32'h0,        0);

    // Reset while an SB sits in DATA: the write must never happen.
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_funct3  = 3'b000;
    req_address = 32'h011;
    req_wdata   = 32'h77;
    @(posedge clock);
    #1;
    req_valid   = 1'b0;
    req_address = '0;
    req_wdata   = '0;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) begin
      @(negedge clock);
      check_eq("rst_mid_no_write", 32'(mem_write_enable), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clock);
    issue("lw_after_rst", 1'b0, 3'b010, 32'h010, 32'h0, 32'hCAFEBEEF, 1'b0, 3, 1, 0, 32'h0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface; sits between the core execute stage and data_memory.
- Turns byte/halfword/word load and store requests into word-granular memory accesses.
- Data memory has no byte enables and a registered 1-cycle read. Sub-word stores are therefore read-modify-write.
- Handles sign/zero extension, alignment and range checks, and a valid/ready handshake toward the core.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in data memory. Legal byte addresses are 0 to MEM_WORDS*4-1.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  core request valid.
- req_ready  output  1  unit can accept a request (IDLE only).
- req_write  input  1  1=store, 0=load.
- req_funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_address  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  response valid.
- resp_ready  input  1  core accepts response.
- resp_rdata  output  32  extended load result; 0 for stores and errors.
- resp_error  output  1  misaligned, out-of-range or illegal funct3.
- mem_address  output  32  word-aligned address to memory ({addr[31:2],2'b00}).
- mem_write_data  output  32  full word to write.
- mem_write_enable  output  1  memory write strobe.
- mem_read_enable  output  1  memory read strobe.
- mem_read_data  input  32  memory read data, valid the cycle after mem_read_enable.

Behaviour:
- Reset (async, immediate): state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_error=0.
- Reset also forces mem_write_enable=0, mem_read_enable=0, mem_address=0, mem_write_data=0. Memory strobes are decoded from state, so they drop as soon as reset asserts.
- Accept: req_valid && req_ready at a rising edge. This captures write, funct3, address and wdata into internal registers. Request inputs are ignored at all other times.
- Error check at accept. Any of the following sends the unit to RESP with resp_error=1 and no memory strobe:
  - address >= MEM_WORDS*4;
  - illegal funct3: 011, 11x, or store with 1xx;
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
- States:
  - IDLE: req_ready=1.
    - Error -> RESP.
    - Load -> RD.
    - SW -> WR.
    - SB/SH -> RD.
  - RD: mem_read_enable=1 for exactly one cycle -> DATA.
  - DATA: mem_read_data valid.
    - Load: extract lane from addr[1:0], sign- or zero-extend, register into resp_rdata -> RESP.
    - SB/SH: merge the wdata byte/half into the read word at lane addr[1:0], register as merged word -> WR.
  - WR: mem_write_enable=1 for one cycle; mem_write_data = wdata (SW) or merged word -> RESP.
  - RESP: resp_valid=1. Hold resp_rdata and resp_error stable until resp_ready. On the resp_valid && resp_ready edge -> IDLE and clear resp_error.
- Latency from accept edge to first resp_valid cycle:
  - error: 1;
  - SW: 2;
  - load: 3;
  - SB/SH: 4.
- Back-to-back: req_ready returns high the cycle after the response handshake. No overlap of requests.
- mem_address holds the captured aligned address in all non-IDLE states, and 0 in IDLE.
- mem_read_enable and mem_write_enable are never both 1 in the same cycle.
- Reset mid-operation aborts the access. An interrupted RMW leaves memory unmodified if reset hits before WR.

Optional Feature:
- LSU_MISALIGN_TRAP_EN
  - Defined: misaligned requests return resp_error=1 as above.
  - Undefined: no misalignment error. The address is force-aligned before lane selection: H uses addr[1], W ignores addr[1:0], B unchanged. The access completes normally with resp_error=0.
  - Range and illegal-funct3 errors remain in both builds.

Decomposition:
- lsu_pkg:
  - state enum (IDLE, RD, DATA, WR, RESP);
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - helper function is_legal_funct3.
- One sub-module, lsu_lane_align, purely combinational:
  - load extract/extend (word, addr[1:0], funct3 -> 32-bit result);
  - store merge (old word, wdata, addr[1:0], funct3 -> new word).
- FSM and registers live in load_store_unit.

Test Plan:
- SW: addr 0x010, wdata 0xDEADBEEF, then LW at 0x010.
  - SW: one mem_write_enable pulse with mem_address=0x010; resp 2 cycles after accept.
  - LW: resp_rdata=0xDEADBEEF, resp_valid 3 cycles after accept.
- SB RMW: after the word above, SB addr 0x012 wdata 0x00000055.
  - Expect read, then write of 0xDE55BEEF.
  - LBU 0x012 returns 0x00000055; LB 0x013 returns 0xFFFFFFDE.
- LH/LHU at 0x010 on 0xDE55BEEF -> 0xFFFFBEEF / 0x0000BEEF.
- Errors, each giving resp_error=1 after 1 cycle with no mem strobe:
  - LW addr 0x1000 (out of range);
  - funct3 011;
  - LH addr 0x011 with LSU_MISALIGN_TRAP_EN defined.
- Backpressure: hold resp_ready=0 for 5 cycles on a load.
  - resp_valid, resp_rdata and resp_error stay stable; req_ready=0; a new req_valid is ignored until the handshake.
- Reset during the DATA state of an SB.
  - No mem_write_enable pulse; outputs at reset values immediately; a subsequent LW returns the original word.
